// File: rtl/mult_accumulator.sv
// Operand sequencer and dot-product accumulator wrapped around a
// 4-bit sequential multiplier, with a watchdog on the multiplier's stop.
module mult_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic [3:0]       mul_x,
  output logic [3:0]       mul_y,
  output logic             mul_start,
  input  logic             mul_stop,
  input  logic [7:0]       mul_p,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  output logic             err
);

  localparam int CW = $clog2(N_TERMS + 1);

  localparam logic [CW-1:0] LAST     = CW'(N_TERMS - 1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [3:0]       x_q, x_d;
  logic [3:0]       y_q, y_d;
  logic [7:0]       p_q, p_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [ACC_W-1:0] acc_add;
  logic             tmo_hit;

  assign acc_add = acc_q + ACC_W'(p_q);

  // A late stop in the last watchdog cycle still wins over the abort.
  assign tmo_hit = (state_q == S_WAIT) && !mul_stop &&
                   (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = a;
          y_d     = b;
          err_d   = 1'b0;
          state_d = S_START;
          if (cnt_q == '0) acc_d = '0;
        end
      end
      S_START: begin
        tmo_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_stop) begin
          p_d     = mul_p;
          state_d = S_ACC;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_ACC: begin
        acc_d = acc_add;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          sum_d   = acc_add;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mul_start = (state_q == S_START);
  assign sum_valid = (state_q == S_DONE);
  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign sum       = sum_q;
  assign err       = err_q | tmo_hit;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator with a behavioural
// variable-latency multiplier model.
module tb_mult_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a, b;
  logic [3:0]  mul_x, mul_y;
  logic        mul_start;
  logic        mul_stop = 1'b0;
  logic [7:0]  mul_p = 8'd0;
  logic [11:0] sum;
  logic        sum_valid;
  logic        err;

  int checks   = 0;
  int failures = 0;

  mult_accumulator #(
    .N_TERMS(4),
    .ACC_W(12),
    .TIMEOUT(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .mul_x(mul_x),
    .mul_y(mul_y),
    .mul_start(mul_start),
    .mul_stop(mul_stop),
    .mul_p(mul_p),
    .sum(sum),
    .sum_valid(sum_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  // Multiplier model: stop first seen high in cycle lat+2 after the
  // handshake; never_stop models a hung multiplier.
  int         lat = 4;
  bit         never_stop = 1'b0;
  int         mcnt = 0;
  logic [3:0] mx = 4'd0;
  logic [3:0] my = 4'd0;

  always @(posedge clk) begin
    if (mul_start) begin
      mcnt     <= lat;
      mul_stop <= 1'b0;
      mx       <= mul_x;
      my       <= mul_y;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt <= 0;
      if (!never_stop) begin
        mul_stop <= 1'b1;
        mul_p    <= mx * my;
      end
    end
  end

  // Protocol monitor, sampled just after the falling edge.
  logic [7:0] q[$];
  int  starts = 0;
  int  svs = 0;
  int  start_viol = 0;
  int  sv_viol = 0;
  int  ready_viol = 0;
  int  sb_err = 0;

  initial begin
    logic hs_prev;
    logic prev_start;
    logic prev_sv;
    logic [7:0] pr;
    hs_prev = 1'b0;
    prev_start = 1'b0;
    prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        q.delete();
        hs_prev = 1'b0;
      end else begin
        if (mul_start) begin
          if (prev_start) start_viol++;
          else starts++;
          if (!prev_start) begin
            if (q.size() == 0) begin
              sb_err++;
            end else begin
              pr = q.pop_front();
              if ({mul_x, mul_y} !== pr) sb_err++;
            end
          end
        end
        if (hs_prev && in_ready) ready_viol++;
        if (sum_valid) begin
          if (prev_sv) sv_viol++;
          else svs++;
          if (in_ready) ready_viol++;
        end
        hs_prev = in_valid && in_ready;
        if (hs_prev) q.push_back({a, b});
      end
      prev_start = mul_start;
      prev_sv = sum_valid;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Returns just after the posedge at which the pair was accepted.
  task automatic send_pair(input logic [3:0] x, input logic [3:0] y);
    int n;
    n = 0;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic run_frame(input logic [15:0] av, input logic [15:0] bv,
                           input int l, input logic [11:0] exp,
                           input string nm);
    int  sv0, st0, n;
    bit  got;
    lat = l;
    sv0 = svs;
    st0 = starts;
    for (int i = 0; i < 4; i++) begin
      send_pair(av[15-4*i -: 4], bv[15-4*i -: 4]);
      if (i == 0) begin
        @(negedge clk);
        chk({nm, "_err_clr"}, {31'd0, err}, 32'd0);
      end
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (sum_valid) got = 1'b1;
    end
    in_valid = 1'b0;
    chk({nm, "_sv_cycle"}, n, l + 4);
    chk({nm, "_sum"}, {20'd0, sum}, {20'd0, exp});
    chk({nm, "_done_busy"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk({nm, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_sv_count"}, svs - sv0, 1);
    chk({nm, "_starts"}, starts - st0, 4);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] av;
    logic [15:0] bv;
    int          l;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int sv0;
    tbl[0] = '{16'h1357, 16'h2468, 4, 12'd100};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 4, 12'd900};
    tbl[2] = '{16'h0021, 16'h9001, 4, 12'd1};
    tbl[3] = '{16'h3333, 16'h3333, 31, 12'd36};
    tbl[4] = '{16'h468A, 16'h579B, 1, 12'd244};

    rst = 1'b1;
    in_valid = 1'b0;
    a = 4'd0;
    b = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_start", {31'd0, mul_start}, 32'd0);
    chk("rst_xy", {24'd0, mul_x, mul_y}, 32'd0);
    chk("rst_sum", {20'd0, sum}, 32'd0);
    chk("rst_sv", {31'd0, sum_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].av, tbl[i].bv, tbl[i].l, tbl[i].exp,
                $sformatf("frame%0d", i));

    // Hung multiplier: watchdog abort timing.
    never_stop = 1'b1;
    sv0 = svs;
    send_pair(4'd5, 4'd5);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (c == 32) chk("tmo_err_pre", {31'd0, err}, 32'd0);
      if (c == 33) begin
        chk("tmo_err_rise", {31'd0, err}, 32'd1);
        chk("tmo_busy", {31'd0, in_ready}, 32'd0);
      end
      if (c == 34) begin
        chk("tmo_ready", {31'd0, in_ready}, 32'd1);
        chk("tmo_err_sticky", {31'd0, err}, 32'd1);
      end
    end
    chk("tmo_no_sv", svs - sv0, 0);
    never_stop = 1'b0;
    run_frame(16'h2222, 16'h3333, 4, 12'd24, "after_tmo");

    // Reset during WAIT of the third term.
    lat = 4;
    sv0 = svs;
    for (int i = 0; i < 3; i++) send_pair(4'd1, 4'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_sum", {20'd0, sum}, 32'd0);
    chk("mid_rst_sv", {31'd0, sum_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_start", {31'd0, mul_start}, 32'd0);
    chk("mid_rst_xy", {24'd0, mul_x, mul_y}, 32'd0);
    rst = 1'b0;
    chk("mid_rst_no_sv", svs - sv0, 0);
    run_frame(16'h1111, 16'h1111, 4, 12'd4, "after_rst");

    repeat (3) @(negedge clk);
    chk("mon_start_width", start_viol, 0);
    chk("mon_sv_width", sv_viol, 0);
    chk("mon_ready_busy", ready_viol, 0);
    chk("mon_scoreboard", sb_err, 0);
    chk("mon_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Sequencer and accumulator that sits around the 4-bit sequential multiplier (`Multiply_4_bit`). It accepts operand pairs over a valid/ready handshake and drives the multiplier's `X`/`Y`/`start`. It waits for `stop`, captures `P` and sums `N_TERMS` products into one dot-product result. A watchdog flags and discards a frame if the multiplier never finishes.

## Interface
- `N_TERMS`, 4: products summed per frame; range 1..16.
- `ACC_W`, 12: accumulator/result width; must be ≥ 8+ceil(log2(N_TERMS)).
- `TIMEOUT`, 32: maximum WAIT cycles before abort; range 2..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair `a`,`b` is valid.
- `in_ready`  out  1  block can accept a pair.
- `a`  in  4  unsigned operand.
- `b`  in  4  unsigned operand.
- `mul_x`  out  4  to multiplier `X`.
- `mul_y`  out  4  to multiplier `Y`.
- `mul_start`  out  1  to multiplier `start`.
- `mul_stop`  in  1  from multiplier `stop`.
- `mul_p`  in  8  from multiplier `P`; valid while `mul_stop`=1.
- `sum`  out  ACC_W  last completed frame result.
- `sum_valid`  out  1  one-cycle pulse when `sum` is updated.
- `err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, START, WAIT, ACC, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`: latch `a`,`b` into `mul_x`,`mul_y` and go to START.
  - If this is the first pair of a frame (`cnt`=0), clear `acc`.
  - Any handshake clears `err`.
- START
  - `mul_start`=1 for exactly one cycle.
  - `mul_x`/`mul_y` stay stable from START until leaving WAIT.
  - Next state: WAIT.
- WAIT
  - Wait for `mul_stop` as a level.
  - Multiplier contract: `stop` is low from the cycle after `start` is sampled until `P` is valid.
  - `mul_stop`=1: go to ACC and capture `mul_p`.
  - Watchdog `tmo` counts WAIT cycles. If `tmo` reaches TIMEOUT-1 without `mul_stop`:
    - set `err`=1;
    - clear `acc` and `cnt`;
    - go to IDLE.
  - The aborted frame produces no `sum_valid`.
- ACC
  - `acc` ← `acc` + zero-extended `mul_p`, modulo 2^ACC_W.
  - If `cnt`=N_TERMS-1: go to DONE and clear `cnt`.
  - Otherwise: increment `cnt` and go to IDLE.
- DONE
  - `sum` ← `acc`, `sum_valid`=1 for one cycle.
  - Go to IDLE.
  - `sum` holds until the next DONE.
- `in_ready`=0 in every state except IDLE. A pair presented while busy is simply held by the upstream side; nothing is dropped or duplicated.
- Reset values:
  - state IDLE;
  - `in_ready`=1;
  - `mul_start`=0, `mul_x`=0, `mul_y`=0;
  - `sum`=0, `sum_valid`=0, `err`=0;
  - `acc`=0, `cnt`=0, `tmo`=0.
- Reset mid-frame discards all partial work. The multiplier has no reset, so the first START after reset restarts it.

## Timing
- Handshake at edge 0 (IDLE, `in_valid`&`in_ready`).
- `mul_start` is high in cycle 1 only.
- WAIT begins in cycle 2.
- If `mul_stop` is first seen high in cycle k:
  - ACC is cycle k+1;
  - for a non-final term, `in_ready` returns high in cycle k+2.
- Final term: DONE (`sum_valid`) in cycle k+2, and `in_ready` returns high in cycle k+3.
- Frame throughput is N_TERMS × (multiplier latency + 3) cycles, plus 1 for DONE.
- Timeout: `err` rises in WAIT cycle TIMEOUT (cycle TIMEOUT+1 after the handshake). `in_ready` is high the next cycle.
- Simultaneous events:
  - `rst` overrides everything.
  - `mul_stop` in the same cycle `tmo` reaches TIMEOUT-1 counts as success, not a timeout.
  - `in_valid` during DONE is not accepted until IDLE.
- N_TERMS=1: every product produces its own `sum_valid`.

## Test plan
- Pairs (1,2),(3,4),(5,6),(7,8) with a behavioural multiplier of 4-cycle latency:
  - exactly one `sum_valid`, with `sum`=100;
  - `mul_start` pulses four times, each exactly one cycle wide.
- Four pairs of (15,15): `sum`=900, no overflow at ACC_W=12. Then a new frame (0,9),(0,0),(2,0),(1,1): `sum`=1, confirming `acc` was cleared.
- Backpressure:
  - hold `in_valid`=1 continuously with new data only after each handshake;
  - `in_ready` is 0 throughout START/WAIT/ACC/DONE;
  - checker confirms every accepted pair is multiplied exactly once.
- Timeout:
  - stub multiplier never raises `stop`; with TIMEOUT=32, `err`=1 at cycle 33 after the handshake;
  - no `sum_valid`;
  - the next handshake clears `err`, and a clean 4-pair frame of (2,3) yields `sum`=24.
- Reset mid-frame: assert `rst` for one cycle during WAIT of the third term.
  - All outputs return to reset values the next cycle (`sum`=0, `in_ready`=1).
  - A following frame (1,1)×4 gives `sum`=4.
- Multiplier raising `stop` with `tmo` at TIMEOUT-1 → product is accumulated, `err` stays 0.
